// File: rtl/csr_trap_ctrl_if.sv
// rtl/csr_trap_ctrl_if.sv - request, response and redirect bundle for csr_trap_ctrl
interface csr_trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [XLEN-1:0] req_pc;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            illegal;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, illegal, redirect_valid, redirect_pc, busy
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, illegal, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - machine-mode CSR file with sequenced ecall/mret trap handling
// Define CSR_TRAP_MCYCLE_EN to add the free-running mcycle counter at 0xB00.
module csr_trap_ctrl #(
    parameter int XLEN        = 64,
    parameter int ECALL_CAUSE = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    csr_trap_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CSR_EXEC  = 3'd1;
    localparam logic [2:0] S_TRAP_SAVE = 3'd2;
    localparam logic [2:0] S_TRAP_JUMP = 3'd3;
    localparam logic [2:0] S_MRET_JUMP = 3'd4;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
`ifdef CSR_TRAP_MCYCLE_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    logic [63:0]     r_mcycle;
`endif

    logic [2:0]      r_state;
    logic [2:0]      r_op;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_pc;

    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mscratch;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic            w_hit;
    logic            w_illegal;
    logic            w_wr;

    // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mie;
    end

    always_comb begin
        w_hit = 1'b1;
        w_old = '0;
        case (r_addr)
            A_MSTATUS:  w_old = w_mstatus;
            A_MTVEC:    w_old = r_mtvec;
            A_MSCRATCH: w_old = r_mscratch;
            A_MEPC:     w_old = r_mepc;
            A_MCAUSE:   w_old = r_mcause;
`ifdef CSR_TRAP_MCYCLE_EN
            A_MCYCLE:   w_old = XLEN'(r_mcycle);
`endif
            default:    w_hit = 1'b0;
        endcase
    end

    always_comb begin
        case (r_op)
            OP_CSRRW: w_new = r_wdata;
            OP_CSRRS: w_new = w_old | r_wdata;
            default:  w_new = w_old & ~r_wdata;
        endcase
    end

    assign w_illegal = (r_op > OP_CSRRC) || !w_hit;
    // Set/clear with a zero mask must leave the CSR untouched, even for side-effect CSRs.
    assign w_wr      = (r_state == S_CSR_EXEC) && !w_illegal &&
                       ((r_op == OP_CSRRW) || (r_wdata != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_pc    <= bus.req_pc;
                        case (bus.req_op)
                            OP_ECALL: r_state <= S_TRAP_SAVE;
                            OP_MRET:  r_state <= S_MRET_JUMP;
                            default:  r_state <= S_CSR_EXEC;
                        endcase
                    end
                end
                S_TRAP_SAVE: r_state <= S_TRAP_JUMP;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mscratch <= '0;
        end else if (r_state == S_TRAP_SAVE) begin
            r_mepc   <= r_pc & ~XLEN'(3);
            r_mcause <= XLEN'(ECALL_CAUSE);
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (r_state == S_MRET_JUMP) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr) begin
            case (r_addr)
                A_MSTATUS: begin
                    r_mie  <= w_new[3];
                    r_mpie <= w_new[7];
                end
                A_MTVEC:    r_mtvec    <= w_new & ~XLEN'(3);
                A_MSCRATCH: r_mscratch <= w_new;
                A_MEPC:     r_mepc     <= w_new & ~XLEN'(3);
                A_MCAUSE:   r_mcause   <= w_new;
                default:    ;
            endcase
        end
    end

`ifdef CSR_TRAP_MCYCLE_EN
    // A software write replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle <= '0;
        end else if (w_wr && (r_addr == A_MCYCLE)) begin
            r_mcycle <= 64'(w_new);
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end
`endif

    assign bus.req_ready      = (r_state == S_IDLE);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.resp_valid     = (r_state == S_CSR_EXEC);
    assign bus.illegal        = (r_state == S_CSR_EXEC) && w_illegal;
    assign bus.resp_rdata     = ((r_state == S_CSR_EXEC) && !w_illegal) ? w_old : '0;
    assign bus.redirect_valid = (r_state == S_TRAP_JUMP) || (r_state == S_MRET_JUMP);
    assign bus.redirect_pc    = (r_state == S_TRAP_JUMP) ? r_mtvec :
                                (r_state == S_MRET_JUMP) ? r_mepc  : '0;
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - self-checking bench for csr_trap_ctrl against a CSR-level reference model
module tb_csr_trap_ctrl;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    longint unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csr_trap_ctrl_if #(.XLEN(XLEN)) bus ();
    csr_trap_ctrl #(.XLEN(XLEN), .ECALL_CAUSE(11)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Reference model: architectural CSR values as plain 64-bit numbers
    logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch, m_mc_w;
    longint unsigned m_mc_c;

    task automatic model_reset();
        m_mstatus = 64'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
        m_mc_w = 0; m_mc_c = cyc;
    endtask

    function automatic bit m_read(input logic [11:0] a, input longint unsigned c, output logic [63:0] v);
        v = 0; m_read = 1'b1;
        case (a)
            12'h300: v = m_mstatus;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
`ifdef CSR_TRAP_MCYCLE_EN
            12'hB00: v = m_mc_w + 64'(c - m_mc_c);
`endif
            default: m_read = 1'b0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [63:0] v, input longint unsigned c);
        case (a)
            12'h300: m_mstatus  = (v & 64'h88) | 64'h1800;
            12'h305: m_mtvec    = v & ~64'h3;
            12'h340: m_mscratch = v;
            12'h341: m_mepc     = v & ~64'h3;
            12'h342: m_mcause   = v;
            12'hB00: begin m_mc_w = v; m_mc_c = c + 1; end
            default: ;
        endcase
    endtask

    task automatic m_step(input logic [2:0] op, input logic [11:0] a, input logic [63:0] wd,
                          input logic [63:0] pc, input longint unsigned c,
                          output logic [63:0] e_rd, output logic e_ill, output logic [63:0] e_rpc);
        logic [63:0] old;
        bit known;
        e_rd = 0; e_ill = 0; e_rpc = 0;
        if (op == 3'd3) begin
            m_mepc = pc & ~64'h3;
            m_mcause = 64'd11;
            m_mstatus = 64'h1800 | ((m_mstatus & 64'h8) << 4);
            e_rpc = m_mtvec;
        end else if (op == 3'd4) begin
            e_rpc = m_mepc;
            m_mstatus = 64'h1880 | ((m_mstatus >> 4) & 64'h8);
        end else begin
            known = m_read(a, c, old);
            if (op > 3'd2 || !known) e_ill = 1'b1;
            else begin
                e_rd = old;
                if (op == 3'd0) m_write(a, wd, c);
                else if (wd != 0) m_write(a, (op == 3'd1) ? (old | wd) : (old & ~wd), c);
            end
        end
    endtask

    // Drives one request from a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_req(input logic [2:0] op, input logic [11:0] a, input logic [63:0] wd,
                           input logic [63:0] pc, input bit hold, output logic [9:0] tmg,
                           output logic [63:0] rd, output logic ill, output logic [63:0] rpc);
        bit rdy;
        int busy_n, resp_n, redir_at;
        rdy = bus.req_ready;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd; bus.req_pc = pc;
        busy_n = 0; resp_n = 0; redir_at = 0; rd = 0; ill = 0; rpc = 0;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (!bus.busy) break;
            busy_n++;
            if (bus.resp_valid) begin resp_n++; rd = bus.resp_rdata; ill = bus.illegal; end
            if (bus.redirect_valid) begin redir_at = c; rpc = bus.redirect_pc; end
            if (hold) begin
                bus.req_op = 3'($urandom); bus.req_addr = 12'($urandom);
                bus.req_wdata = {$urandom, $urandom}; bus.req_pc = {$urandom, $urandom};
            end else bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        tmg = {rdy, 3'(busy_n), 3'(resp_n), 3'(redir_at)};
    endtask

    task automatic do_op(input logic [2:0] op, input logic [11:0] a, input logic [63:0] wd,
                         input logic [63:0] pc, input bit hold,
                         output logic [9:0] tmg, output logic [9:0] e_tmg,
                         output logic [63:0] rd, output logic ill, output logic [63:0] rpc,
                         output logic [63:0] e_rd, output logic e_ill, output logic [63:0] e_rpc);
        m_step(op, a, wd, pc, cyc + 1, e_rd, e_ill, e_rpc);
        e_tmg = {1'b1, (op == 3'd3) ? 3'd2 : 3'd1, (op == 3'd3 || op == 3'd4) ? 3'd0 : 3'd1,
                 (op == 3'd3) ? 3'd2 : (op == 3'd4) ? 3'd1 : 3'd0};
        run_req(op, a, wd, pc, hold, tmg, rd, ill, rpc);
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_pc = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.busy, bus.resp_valid, bus.illegal, bus.redirect_valid} !== 5'b10000 ||
            bus.resp_rdata !== 64'h0 || bus.redirect_pc !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs ready/busy/resp/ill/redir=%b rdata=%h rpc=%h want 10000/0/0",
                     {bus.req_ready, bus.busy, bus.resp_valid, bus.illegal, bus.redirect_valid},
                     bus.resp_rdata, bus.redirect_pc);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_csr_mtvec();
        logic [9:0] t, et; logic [63:0] rd, erd, rp, erp; logic il, eil;
        do_op(3'd0, 12'h305, 64'h8000_0103, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (t !== et || rd !== 64'h0 || il !== 1'b0) begin
            failures++; $display("FAIL mtvec_write tmg=%h rdata=%h ill=%b want tmg=%h 0/0", t, rd, il, et);
        end
        do_op(3'd1, 12'h305, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (t !== et || rd !== 64'h8000_0100 || il !== 1'b0) begin
            failures++; $display("FAIL mtvec_readback tmg=%h rdata=%h want 0000000080000100", t, rd);
        end
        do_op(3'd1, 12'h305, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'h8000_0100) begin
            failures++; $display("FAIL mtvec_csrrs_zero_nowrite rdata=%h want 0000000080000100", rd);
        end
    endtask

    task automatic test_ecall_mret();
        logic [9:0] t, et; logic [63:0] rd, erd, rp, erp; logic il, eil;
        do_op(3'd1, 12'h300, 64'h8, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'h1800) begin failures++; $display("FAIL mstatus_reset_read rdata=%h want 1800", rd); end
        do_op(3'd3, 12'h0, 64'h0, 64'h8000_0040, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (t !== 10'b1_010_000_010 || rp !== 64'h8000_0100) begin
            failures++; $display("FAIL ecall_redirect tmg=%b rpc=%h want 1010000010 0000000080000100", t, rp);
        end
        do_op(3'd1, 12'h341, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'h8000_0040) begin failures++; $display("FAIL ecall_mepc rdata=%h want 80000040", rd); end
        do_op(3'd1, 12'h342, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'd11) begin failures++; $display("FAIL ecall_mcause rdata=%h want b", rd); end
        do_op(3'd1, 12'h300, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'h1880) begin failures++; $display("FAIL ecall_mstatus rdata=%h want 1880", rd); end
        do_op(3'd4, 12'h0, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (t !== 10'b1_001_000_001 || rp !== 64'h8000_0040) begin
            failures++; $display("FAIL mret_redirect tmg=%b rpc=%h want 1001000001 80000040", t, rp);
        end
        do_op(3'd1, 12'h300, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'h1888) begin failures++; $display("FAIL mret_mstatus rdata=%h want 1888", rd); end
    endtask

    task automatic test_mscratch_illegal();
        logic [9:0] t, et; logic [63:0] rd, erd, rp, erp; logic il, eil;
        logic [11:0] alist [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
        do_op(3'd0, 12'h340, 64'hFF, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        do_op(3'd2, 12'h340, 64'h0F, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'hFF || il !== 1'b0) begin failures++; $display("FAIL csrrc_old rdata=%h ill=%b want ff/0", rd, il); end
        do_op(3'd1, 12'h340, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'hF0) begin failures++; $display("FAIL csrrc_result rdata=%h want f0", rd); end
        do_op(3'd0, 12'h7C0, 64'hDEAD_BEEF, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (t !== et || rd !== 64'h0 || il !== 1'b1) begin
            failures++; $display("FAIL bad_addr tmg=%h rdata=%h ill=%b want 0/1", t, rd, il);
        end
        do_op(3'd6, 12'h340, 64'h1234, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'h0 || il !== 1'b1) begin failures++; $display("FAIL bad_op rdata=%h ill=%b want 0/1", rd, il); end
        foreach (alist[i]) begin
            do_op(3'd1, alist[i], 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
            checks++;
            if (rd !== erd || il !== eil) begin
                failures++; $display("FAIL no_change addr=%h rdata=%h want %h", alist[i], rd, erd);
            end
        end
    endtask

    task automatic test_reset_mid_trap();
        logic [9:0] t, et; logic [63:0] rd, erd, rp, erp; logic il, eil;
        do_op(3'd0, 12'h305, 64'h1000, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_pc = 64'h2000;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_trap redir=%b ready=%b busy=%b want 0/1/0",
                                 bus.redirect_valid, bus.req_ready, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_op(3'd1, 12'h305, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'h0) begin failures++; $display("FAIL reset_mtvec rdata=%h want 0", rd); end
        do_op(3'd1, 12'h300, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
        if (rd !== 64'h1800) begin failures++; $display("FAIL reset_mstatus rdata=%h want 1800", rd); end
    endtask

    task automatic test_mcycle();
        logic [9:0] t, et; logic [63:0] rd, erd, rp, erp; logic il, eil;
        do_op(3'd0, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        @(negedge clk);
        do_op(3'd1, 12'hB00, 64'h0, 64'h0, 1'b0, t, et, rd, il, rp, erd, eil, erp);
        checks++;
`ifdef CSR_TRAP_MCYCLE_EN
        if (rd !== 64'h0 || il !== 1'b0) begin failures++; $display("FAIL mcycle_wrap rdata=%h ill=%b want 0/0", rd, il); end
`else
        if (rd !== 64'h0 || il !== 1'b1) begin failures++; $display("FAIL mcycle_absent rdata=%h ill=%b want 0/1", rd, il); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [9:0] t, et; logic [63:0] rd, erd, rp, erp; logic il, eil;
        logic [11:0] alist [7] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'h7C0};
        logic [2:0] op; logic [11:0] a; logic [63:0] wd, pc;
        for (int n = 0; n < 120; n++) begin
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 7) ? 12'($urandom) : alist[$urandom_range(0, 6)];
            wd = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            pc = {$urandom, $urandom};
            do_op(op, a, wd, pc, 1'($urandom), t, et, rd, il, rp, erd, eil, erp);
            checks++;
            if (t !== et || rd !== erd || il !== eil || rp !== erp) begin
                failures++;
                $display("FAIL rand_%0d op=%0d addr=%h tmg=%h/%h rdata=%h/%h ill=%b/%b rpc=%h/%h (got/want)",
                         n, op, a, t, et, rd, erd, il, eil, rp, erp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_csr_mtvec();
        test_ecall_mret();
        test_mscratch_illegal();
        test_reset_mid_trap();
        test_mcycle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
